// File: rtl/icache_ctrl_if.sv
// Bundled fetch, response, data-BRAM and TileLink-UL A/D signals of the icache sequencer.
// The slave modport is the controller's view; master is the surrounding core/memory side.
interface icache_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic                  resp_err;
  logic                  flush;
  logic [9:0]            bram_rd_addr;
  logic                  bram_rd_en;
  logic [31:0]           bram_rd_data;
  logic [9:0]            bram_wr_addr;
  logic [31:0]           bram_wr_data;
  logic                  bram_wr_en;
  logic [2:0]            a_opcode;
  logic [2:0]            a_param;
  logic [3:0]            a_size;
  logic [ADDR_WIDTH-1:0] a_address;
  logic [3:0]            a_mask;
  logic [31:0]           a_data;
  logic                  a_corrupt;
  logic                  a_valid;
  logic                  a_ready;
  logic [2:0]            d_opcode;
  logic [1:0]            d_param;
  logic [3:0]            d_size;
  logic                  d_denied;
  logic [31:0]           d_data;
  logic                  d_corrupt;
  logic                  d_valid;
  logic                  d_ready;

  modport slave (
    input  req_valid, req_addr, resp_ready, flush, bram_rd_data, a_ready,
           d_opcode, d_param, d_size, d_denied, d_data, d_corrupt, d_valid,
    output req_ready, resp_valid, resp_data, resp_err, bram_rd_addr, bram_rd_en,
           bram_wr_addr, bram_wr_data, bram_wr_en, a_opcode, a_param, a_size,
           a_address, a_mask, a_data, a_corrupt, a_valid, d_ready
  );

  modport master (
    output req_valid, req_addr, resp_ready, flush, bram_rd_data, a_ready,
           d_opcode, d_param, d_size, d_denied, d_data, d_corrupt, d_valid,
    input  req_ready, resp_valid, resp_data, resp_err, bram_rd_addr, bram_rd_en,
           bram_wr_addr, bram_wr_data, bram_wr_en, a_opcode, a_param, a_size,
           a_address, a_mask, a_data, a_corrupt, a_valid, d_ready
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache sequencer: tag/valid lookup, single-line TL-UL Get refill into
// the data BRAM, one fetch in flight at a time.
module icache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 128
) (
  input  logic         i_clk,
  input  logic         i_rst,
  icache_ctrl_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
  localparam logic [3:0] GET_SIZE = 4'($clog2(LINE_WORDS * 4));

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MISS_REQ = 3'd2;
  localparam logic [2:0] S_REFILL   = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]       r_state;
  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag_mem [SETS];
  logic [OFF_W-1:0] r_off;
  logic [OFF_W-1:0] r_beat;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_flush_pend;
  logic             r_err;
  logic [31:0]      r_resp_data;
  logic             r_resp_err;
  logic             r_wr_en;
  logic [9:0]       r_wr_addr;
  logic [31:0]      r_wr_data;

  logic [OFF_W-1:0]      w_req_off;
  logic [IDX_W-1:0]      w_req_idx;
  logic [TAG_W-1:0]      w_req_tag;
  logic                  w_flush_now;
  logic                  w_accept;
  logic                  w_hit;
  logic                  w_last;
  logic                  w_err_next;
  logic                  w_a_valid;
  logic [ADDR_WIDTH-1:0] w_line_addr;
  logic                  w_unused_bits;

  assign w_req_off   = bus.req_addr[OFF_W+1:2];
  assign w_req_idx   = bus.req_addr[OFF_W+2 +: IDX_W];
  assign w_req_tag   = bus.req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_flush_now = (r_state == S_IDLE) && (bus.flush || r_flush_pend);
  assign w_accept    = (r_state == S_IDLE) && !w_flush_now && bus.req_valid;
  assign w_hit       = r_valid[r_idx] && (r_tag_mem[r_idx] == r_tag);
  assign w_last      = (r_beat == OFF_W'(LINE_WORDS - 1));
  assign w_err_next  = r_err | bus.d_denied | bus.d_corrupt;
  assign w_a_valid   = (r_state == S_MISS_REQ);
  assign w_line_addr = {r_tag, r_idx, {(OFF_W + 2){1'b0}}};
  // Opcode/param/size of D beats carry nothing the sequencer acts on.
  assign w_unused_bits = ^{bus.d_opcode, bus.d_param, bus.d_size, bus.req_addr[1:0]};

  assign bus.req_ready    = (r_state == S_IDLE) && !bus.flush && !r_flush_pend;
  assign bus.bram_rd_en   = w_accept;
  assign bus.bram_rd_addr = w_accept ? 10'({w_req_idx, w_req_off}) : 10'd0;
  assign bus.bram_wr_en   = r_wr_en;
  assign bus.bram_wr_addr = r_wr_addr;
  assign bus.bram_wr_data = r_wr_data;
  // A fields are held at zero while idle so the channel is quiet outside a Get.
  assign bus.a_valid      = w_a_valid;
  assign bus.a_opcode     = w_a_valid ? 3'd4 : 3'd0;
  assign bus.a_param      = 3'd0;
  assign bus.a_size       = w_a_valid ? GET_SIZE : 4'd0;
  assign bus.a_address    = w_a_valid ? w_line_addr : {ADDR_WIDTH{1'b0}};
  assign bus.a_mask       = w_a_valid ? 4'hF : 4'h0;
  assign bus.a_data       = 32'd0;
  assign bus.a_corrupt    = 1'b0;
  assign bus.d_ready      = (r_state == S_REFILL);
  assign bus.resp_valid   = (r_state == S_RESP);
  assign bus.resp_data    = r_resp_data;
  assign bus.resp_err     = r_resp_err;

  // Sequencer state, valid bits, pending flush and refill write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_off        <= '0;
      r_idx        <= '0;
      r_tag        <= '0;
      r_beat       <= '0;
      r_err        <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_err   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 10'd0;
      r_wr_data    <= 32'd0;
    end else begin
      r_wr_en <= 1'b0;
      if (bus.flush && (r_state != S_IDLE)) begin
        r_flush_pend <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_flush_now) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end else if (bus.req_valid) begin
            r_off   <= w_req_off;
            r_idx   <= w_req_idx;
            r_tag   <= w_req_tag;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_resp_data <= bus.bram_rd_data;
            r_resp_err  <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_state <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          if (bus.a_ready) begin
            r_valid[r_idx] <= 1'b0;
            r_beat         <= '0;
            r_err          <= 1'b0;
            r_state        <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (bus.d_valid) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= 10'({r_idx, r_beat});
            r_wr_data <= bus.d_data;
            r_err     <= w_err_next;
            r_beat    <= r_beat + OFF_W'(1);
            if (r_beat == r_off) begin
              r_resp_data <= bus.d_data;
            end
            if (w_last) begin
              r_valid[r_idx] <= !w_err_next;
              r_resp_err     <= w_err_next;
              r_state        <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag array needs no reset: an entry is only consulted behind its valid bit.
  always_ff @(posedge i_clk) begin
    if ((r_state == S_REFILL) && bus.d_valid && w_last) begin
      r_tag_mem[r_idx] <= r_tag;
    end
  end
endmodule
